// File: rtl/boron_key_pkg.sv
// rtl/boron_key_pkg.sv - shared constants and types for the Boron key schedulers
package boron_key_pkg;

  localparam int KEY_BITS       = 80;
  localparam int NUM_ROUND_KEYS = 26;
  localparam int ROT_AMOUNT     = 13;

  typedef logic [4:0] idx_t;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  localparam idx_t LAST_IDX = idx_t'(NUM_ROUND_KEYS - 1);

  // Element 0 is the first entry so SBOX[x] reads naturally.
  localparam logic [0:15][3:0] SBOX = {
    4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
    4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
  };

endpackage

// File: rtl/enc_key_round.sv
// rtl/enc_key_round.sv - one forward key-register update (rotate, S-box, counter xor)
module enc_key_round
  import boron_key_pkg::*;
(
  input  logic [KEY_BITS-1:0] key,
  input  logic [4:0]          round_ctr,
  output logic [KEY_BITS-1:0] next_key
);

  logic [KEY_BITS-1:0] rot;

  assign rot = {key[KEY_BITS-1-ROT_AMOUNT:0], key[KEY_BITS-1:KEY_BITS-ROT_AMOUNT]};

  always_comb begin
    next_key        = rot;
    next_key[3:0]   = SBOX[rot[3:0]];
    next_key[63:59] = rot[63:59] ^ round_ctr;
  end

endmodule

// File: rtl/enc_key_scheduler.sv
// rtl/enc_key_scheduler.sv - streams Boron round keys K0..K25 and returns the final key register
module enc_key_scheduler
  import boron_key_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] master_key,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [63:0]         rk,
  output logic [4:0]          rk_index,
  output logic                done,
  output logic [KEY_BITS-1:0] last_key
);

  state_t              state;
  idx_t                idx;
  logic [KEY_BITS-1:0] key_reg;
  logic [KEY_BITS-1:0] next_key;

  enc_key_round u_round (
    .key       (key_reg),
    .round_ctr (idx + 5'd1),
    .next_key  (next_key)
  );

  assign rk_valid = (state == ST_RUN);
  assign busy     = (state == ST_RUN) || (state == ST_DONE);
  assign done     = (state == ST_DONE);
  assign rk       = rk_valid ? key_reg[63:0] : 64'h0;
  assign rk_index = rk_valid ? idx : 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      key_reg  <= '0;
      last_key <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_reg <= master_key;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rk_ready) begin
            // The final key is captured as-is; the register is not advanced past K25.
            if (idx == LAST_IDX) begin
              last_key <= key_reg;
              state    <= ST_DONE;
            end else begin
              key_reg <= next_key;
              idx     <= idx + 5'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/enc_key_scheduler.md
# enc_key_scheduler

Sequential encryption-side key scheduler for the Boron block cipher, the forward counterpart of the decryption key update. It loads an 80-bit master key, streams the 26 round keys K0..K25 (least significant 64 bits of the key register) to the encryption datapath over a valid/ready handshake, and returns the final 80-bit key register. That final key is the starting key for the decryption scheduler.

## Interface
- KEY_BITS, 80, key register width; only 80 is supported.
- NUM_ROUND_KEYS, 26, round keys emitted (K0 plus 25 updates); the round counter is 5 bits.
- ROT_AMOUNT, 13, left-rotation amount per update.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  load request; sampled only in IDLE.
- master_key  in  80  key loaded on an accepted start.
- busy  out  1  high in RUN and DONE.
- rk_valid  out  1  round key presented.
- rk_ready  in  1  consumer accepts the round key.
- rk  out  64  key_reg[63:0] while rk_valid is high, else 0.
- rk_index  out  5  index of the presented key, 0..25.
- done  out  1  one-cycle pulse after K25 is accepted.
- last_key  out  80  key_reg after the final update; held until the next accepted start.

## Operation
- States are IDLE, RUN and DONE, encoded in 2 bits. Encoding 2'b11 is illegal and returns to IDLE.
- IDLE:
  - start=1 loads key_reg←master_key and idx←0, then goes to RUN.
  - start=0 stays in IDLE.
- RUN:
  - rk_valid=1, rk=key_reg[63:0], rk_index=idx.
  - On a handshake (rk_valid & rk_ready) with idx<NUM_ROUND_KEYS-1: key_reg←update(key_reg, idx+1) and idx←idx+1.
  - On a handshake with idx=NUM_ROUND_KEYS-1: last_key←key_reg, then go to DONE. key_reg is not updated.
  - With no handshake, key_reg, idx and the outputs hold stable.
- DONE: done=1 for one cycle, rk_valid=0, then go to IDLE.
- update(k, c) uses 80-bit arithmetic with no carries:
  - t = k rotated left by ROT_AMOUNT.
  - t[3:0] ← SBOX[t[3:0]].
  - t[63:59] ← t[63:59] ^ c[4:0].
  - All other bits pass through unchanged.
- SBOX, input 0..F: E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
- Applying the decryption key update to last_key with counters 25 down to 1 yields master_key exactly.
- start while busy is ignored. There is no queuing and no error flag.
- rk_ready while rk_valid=0 has no effect.
- rk_valid never drops without a handshake, and rk/rk_index are stable while rk_valid=1 and rk_ready=0.

## Timing
- The reset value of every output is 0: busy, rk_valid, rk, rk_index, done and last_key. Reset also clears key_reg and idx and sets the state to IDLE.
- Reset has priority over start and over a handshake in the same cycle.
- Reset mid-RUN aborts in the next cycle. There is no done pulse, and last_key reads 0.
- Start accepted at edge N:
  - rk_valid=1 with rk_index=0 from cycle N+1.
  - With rk_ready held at 1, one key per cycle: rk_index=25 in cycle N+26, done=1 in cycle N+27.
  - IDLE from cycle N+28; a new start is accepted at the end of cycle N+28.
- Latency from a handshake to the next key is one cycle. The update is purely combinational between registers, so there are no pipeline bubbles.
- last_key is valid in the same cycle as done.

## Structure
- Package boron_key_pkg holds:
  - KEY_BITS, NUM_ROUND_KEYS and ROT_AMOUNT.
  - The 2-bit state type (IDLE, RUN, DONE).
  - The SBOX constant as a 16×4 array.
  - The index type logic [4:0].
- Sub-module enc_key_round, combinational: inputs key[79:0] and round_ctr[4:0], output next_key[79:0]. It implements update(). The FSM, idx counter and key_reg live in the top module.

## Test plan
- Zero key:
  - Stimulus: master_key=80'h0, rk_ready=1.
  - Required: rk0=64'h0, rk1=64'h0800_0000_0000_000E, rk_index sequence 0..25, done in cycle N+27.
- Back-pressure:
  - Stimulus: random master_key; rk_ready low for 5 cycles at idx=3, and toggled randomly thereafter.
  - Required: rk/rk_index constant while stalled, no key skipped or repeated, and 26 handshakes total.
- Round trip:
  - Stimulus: master_key=80'hFFFF_FFFF_FFFF_FFFF_FFFF and 80'h0123_4567_89AB_CDEF_0123.
  - Required: the decryption key update applied 25× to last_key (counters 25..1) returns master_key.
- Start while busy:
  - Stimulus: pulse start with a different master_key at idx=10.
  - Required: the stream continues unchanged and last_key matches the original key.
- Reset mid-run:
  - Stimulus: assert rst at idx=12, together with rk_ready=1.
  - Required: all outputs 0 the next cycle, no done pulse, and a following start produces a clean stream from index 0.
- Back-to-back:
  - Stimulus: assert start in the cycle done=1, then again in the first IDLE cycle.
  - Required: the first start is ignored and the second is accepted, giving rk_valid two cycles after done.
